store_buffer: RTL

- Parametrised N-entry FIFO store buffer between the MEM stage and the data cache.
- Generalises the fixed store/load control encoding (OTHER=00, IS_LOAD=01, IS_STORE=10) and byte/word sizing (B=0, W=1) into a configurable-depth block.
- Retires committed stores to the cache in program order through a valid/ready drain port.
- Forwards buffered data to younger loads, or flags a conflict when forwarding is impossible.

---
 rtl/store_buffer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// Store buffer: N-entry FIFO of committed stores sitting between the MEM stage
// and the data cache. Stores drain in program order through a valid/ready port;
// younger loads are forwarded from the buffer or flagged as conflicting.
module store_buffer #(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  input  logic [1:0]            req_ctrl_i,
  input  logic                  req_size_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  output logic                  stall_o,
  output logic                  ld_hit_o,
  output logic [DATA_WIDTH-1:0] ld_data_o,
  output logic                  ld_conflict_o,
  output logic                  drain_valid_o,
  output logic [ADDR_WIDTH-1:0] drain_addr_o,
  output logic [DATA_WIDTH-1:0] drain_data_o,
  output logic                  drain_size_o,
  input  logic                  drain_ready_i,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int unsigned PtrW = $clog2(NUM_ENTRIES);
  localparam int unsigned CntW = PtrW + 1;
  // Byte-offset bits within a word (2 for 32-bit words).
  localparam int unsigned OffW = $clog2(DATA_WIDTH / 8);

  localparam logic [1:0] CtrlLoad  = 2'b01;
  localparam logic [1:0] CtrlStore = 2'b10;

  logic [ADDR_WIDTH-1:0] addr_q [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0] data_q [NUM_ENTRIES];
  logic                  size_q [NUM_ENTRIES];

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic                  is_store, is_load;
  logic                  enq, deq;
  logic [ADDR_WIDTH-1:0] enq_addr;
  logic [DATA_WIDTH-1:0] enq_data;

  assign is_store = req_valid_i && (req_ctrl_i == CtrlStore);
  assign is_load  = req_valid_i && (req_ctrl_i == CtrlLoad);

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(NUM_ENTRIES));

  // Full is judged on the registered count, so a same-cycle drain still stalls.
  assign stall_o = is_store && full_o;
  assign enq     = is_store && !full_o;
  assign deq     = !empty_o && drain_ready_i;

  // Word stores are forced word-aligned; byte stores keep only the low lane.
  assign enq_addr = req_size_i ? {req_addr_i[ADDR_WIDTH-1:OffW], OffW'(0)} : req_addr_i;
  assign enq_data = req_size_i ? req_data_i : DATA_WIDTH'(req_data_i[7:0]);

  // Head entry shown to the cache; zeroed while empty so reset leaves outputs at 0.
  assign drain_valid_o = !empty_o;
  assign drain_addr_o  = empty_o ? '0   : addr_q[head_q];
  assign drain_data_o  = empty_o ? '0   : data_q[head_q];
  assign drain_size_o  = empty_o ? 1'b0 : size_q[head_q];

  // Pointer and occupancy next-state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) tail_d = tail_q + PtrW'(1);
    if (deq) head_d = head_q + PtrW'(1);
    unique case ({enq, deq})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are only observed through count-qualified logic.
  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      addr_q[tail_q] <= enq_addr;
      data_q[tail_q] <= enq_data;
      size_q[tail_q] <= req_size_i;
    end
  end

  logic [PtrW-1:0] idx;
  logic            same_word;
  logic [7:0]      lane_byte;

  // Load lookup: walk oldest to youngest so the youngest matching entry decides.
  always_comb begin
    ld_hit_o      = 1'b0;
    ld_conflict_o = 1'b0;
    ld_data_o     = '0;
    idx           = '0;
    same_word     = 1'b0;
    lane_byte     = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      idx       = head_q + PtrW'(i);
      same_word = (addr_q[idx][ADDR_WIDTH-1:OffW] == req_addr_i[ADDR_WIDTH-1:OffW]);
      lane_byte = 8'(data_q[idx] >> {req_addr_i[OffW-1:0], 3'b000});
      if (is_load && (CntW'(i) < count_q) && same_word) begin
        if (size_q[idx]) begin
          ld_hit_o      = 1'b1;
          ld_conflict_o = 1'b0;
          ld_data_o     = req_size_i ? data_q[idx] : DATA_WIDTH'(lane_byte);
        end else if (!req_size_i) begin
          // Byte entry only answers a byte load at the exact same address.
          if (addr_q[idx][OffW-1:0] == req_addr_i[OffW-1:0]) begin
            ld_hit_o      = 1'b1;
            ld_conflict_o = 1'b0;
            ld_data_o     = DATA_WIDTH'(data_q[idx][7:0]);
          end
        end else begin
          // Word load over a buffered byte cannot be assembled here.
          ld_hit_o      = 1'b0;
          ld_conflict_o = 1'b1;
          ld_data_o     = '0;
        end
      end
    end
  end

endmodule
